// File: rtl/fp_mult_round.sv
// IEEE-754 single-precision multiply back end: classifies the operands at issue, then
// normalizes and rounds an external LAT-cycle mantissa product. Define FP_MULT_RNE_EN to get round-to-nearest-even; otherwise the result is truncated.
module fp_mult_round #(
    parameter int LAT = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] prod,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    // CL_NAN covers every invalid case (NaN operand or Inf x Zero)
    typedef enum logic [1:0] {CL_NORM, CL_ZERO, CL_INF, CL_NAN} cls_t;

    typedef struct packed {
        logic               sgn;
        logic signed [9:0]  exp;
        cls_t               cls;
    } meta_t;

    logic [7:0]  ea, eb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    meta_t       issue_meta;

    logic [LAT:1] vld_pipe;
    meta_t        meta_pipe [1:LAT];

    logic              n_vld, n_g, n_s;
    meta_t             n_meta;
    logic [23:0]       n_mant;
    logic [23:0]       nrm_mant;
    logic              nrm_g, nrm_s;
    logic signed [9:0] nrm_exp;

    logic              inc;
    logic [30:0]       ovf_val;
    logic [24:0]       m25;
    logic [23:0]       mant_r;
    logic signed [9:0] exp_r;
    logic [31:0]       res_c;
    logic [3:0]        flg_c;

    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[63:48];

    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign a_nan  = (&ea) & (|a[22:0]);
    assign b_nan  = (&eb) & (|b[22:0]);
    assign a_inf  = (&ea) & ~(|a[22:0]);
    assign b_inf  = (&eb) & ~(|b[22:0]);
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    always_comb begin
        issue_meta.sgn = a[31] ^ b[31];
        issue_meta.exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            issue_meta.cls = CL_NAN;
        else if (a_inf || b_inf)
            issue_meta.cls = CL_INF;
        else if (a_zero || b_zero)
            issue_meta.cls = CL_ZERO;
        else
            issue_meta.cls = CL_NORM;
    end

    // Side-band shift register lines sign/exponent/class up with prod
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= LAT; i++) meta_pipe[i] <= '0;
        end else begin
            vld_pipe     <= LAT'({vld_pipe, in_valid});
            meta_pipe[1] <= issue_meta;
            for (int i = 2; i <= LAT; i++) meta_pipe[i] <= meta_pipe[i-1];
        end
    end

    always_comb begin
        if (prod[47]) begin
            nrm_mant = prod[47:24];
            nrm_g    = prod[23];
            nrm_s    = |prod[22:0];
            nrm_exp  = meta_pipe[LAT].exp + 10'sd1;
        end else begin
            nrm_mant = prod[46:23];
            nrm_g    = prod[22];
            nrm_s    = |prod[21:0];
            nrm_exp  = meta_pipe[LAT].exp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_vld  <= 1'b0;
            n_meta <= '0;
            n_mant <= '0;
            n_g    <= 1'b0;
            n_s    <= 1'b0;
        end else begin
            n_vld <= vld_pipe[LAT];
            if (vld_pipe[LAT]) begin
                n_meta.sgn <= meta_pipe[LAT].sgn;
                n_meta.cls <= meta_pipe[LAT].cls;
                n_meta.exp <= nrm_exp;
                n_mant     <= nrm_mant;
                n_g        <= nrm_g;
                n_s        <= nrm_s;
            end
        end
    end

`ifdef FP_MULT_RNE_EN
    assign inc     = n_g & (n_s | n_mant[0]);
    assign ovf_val = 31'h7F80_0000;
`else
    assign inc     = 1'b0;
    assign ovf_val = 31'h7F7F_FFFF;
`endif

    always_comb begin
        m25    = {1'b0, n_mant} + {24'd0, inc};
        mant_r = m25[23:0];
        exp_r  = n_meta.exp;
        if (m25[24]) begin
            mant_r = 24'h80_0000;
            exp_r  = n_meta.exp + 10'sd1;
        end
        res_c = 32'd0;
        flg_c = 4'd0;
        case (n_meta.cls)
            CL_NAN: begin
                res_c = 32'h7FC0_0000;
                flg_c = 4'b1000;
            end
            CL_INF:  res_c = {n_meta.sgn, 31'h7F80_0000};
            CL_ZERO: res_c = {n_meta.sgn, 31'd0};
            default: begin
                if (exp_r >= 10'sd255) begin
                    res_c = {n_meta.sgn, ovf_val};
                    flg_c = 4'b0101;
                end else if (exp_r <= 10'sd0) begin
                    res_c = {n_meta.sgn, 31'd0};
                    flg_c = 4'b0011;
                end else begin
                    res_c = {n_meta.sgn, exp_r[7:0], mant_r[22:0]};
                    flg_c = {3'b000, n_g | n_s};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            out_valid <= n_vld;
            if (n_vld) begin
                result <= res_c;
                flags  <= flg_c;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_round.sv
// Bench for fp_mult_round: directed vectors plus random operands checked cycle by cycle
// against an arithmetic reference model; plays the role of the external multiplier.
module tb_fp_mult_round;

    localparam int LAT = 10;
    localparam int N   = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [63:0] prod = '0;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          iss [0:N-1];
    logic [63:0] pp  [0:N-1];
    bit          ev  [0:N+LAT+3];
    logic [31:0] er  [0:N+LAT+3];
    logic [3:0]  ef  [0:N+LAT+3];
    logic [31:0] hold_r = '0;
    logic [3:0]  hold_f = '0;

    fp_mult_round #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .prod(prod), .out_valid(out_valid), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    // Exact product rounded with integer quotient/remainder arithmetic
    function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        int ex, ey, e, sh;
        bit sg, xn, yn, xi, yi, xz, yz, up, inx;
        longint unsigned p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sg = x[31] ^ y[31];
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xz = (ex == 0);
        yz = (ey == 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return {4'b1000, 32'h7FC0_0000};
        if (xi || yi) return {4'b0000, sg, 31'h7F80_0000};
        if (xz || yz) return {4'b0000, sg, 31'd0};
        p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
        if (p >= (64'd1 << 47)) begin sh = 24; e = ex + ey - 126; end
        else begin sh = 23; e = ex + ey - 127; end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
`ifdef FP_MULT_RNE_EN
        up = (rem > half) || ((rem == half) && q[0]);
`else
        up = 1'b0;
`endif
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e++; end
`ifdef FP_MULT_RNE_EN
        if (e >= 255) return {4'b0101, sg, 31'h7F80_0000};
`else
        if (e >= 255) return {4'b0101, sg, 31'h7F7F_FFFF};
`endif
        if (e <= 0) return {4'b0011, sg, 31'd0};
        return {3'b000, inx, sg, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] m;
        m = 32'($urandom) & 32'h007F_FFFF;
        case ($urandom_range(0, 9))
            0: return {1'($urandom), 8'd0, (($urandom_range(0, 1) == 1) ? m[22:0] : 23'd0)};
            1: return {1'($urandom), 8'hFF, 23'd0};
            2: return {1'($urandom), 8'hFF, m[22:0] | 23'd1};
            3: return {1'($urandom), 8'($urandom_range(240, 254)), m[22:0]};
            4: return {1'($urandom), 8'($urandom_range(1, 15)), m[22:0]};
            default: return {1'($urandom), 8'($urandom_range(100, 154)), m[22:0]};
        endcase
    endfunction

    // One clock: optional reset, output checks, then drive this cycle's inputs
    task automatic do_cycle(input bit rst, input bit v, input logic [31:0] xa, input logic [31:0] xb,
                            input bit dir, input logic [31:0] dr, input logic [3:0] df);
        logic [35:0] r;
        @(negedge clk);
        if (rst) begin
            rst_n = 1'b0;
            #1;
            for (int k = 0; k < N; k++) iss[k] = 1'b0;
            for (int k = cyc; k < N + LAT + 4; k++) ev[k] = 1'b0;
            hold_r = '0;
            hold_f = '0;
        end else begin
            rst_n = 1'b1;
        end
        if (ev[cyc]) begin
            hold_r = er[cyc];
            hold_f = ef[cyc];
        end
        checks++;
        assert (out_valid === ev[cyc]) else begin
            errors++;
            $error("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, ev[cyc]);
        end
        checks++;
        assert (result === hold_r) else begin
            errors++;
            $error("FAIL result cyc=%0d got=%h exp=%h", cyc, result, hold_r);
        end
        checks++;
        assert (flags === hold_f) else begin
            errors++;
            $error("FAIL flags cyc=%0d got=%b exp=%b", cyc, flags, hold_f);
        end
        in_valid = v & ~rst;
        a = xa;
        b = xb;
        if (cyc >= LAT && iss[cyc-LAT]) prod = pp[cyc-LAT];
        else prod = {$urandom, $urandom};
        iss[cyc] = v & ~rst;
        pp[cyc]  = 64'({1'b1, xa[22:0]}) * 64'({1'b1, xb[22:0]});
        if (v && !rst) begin
            r = ref_mul(xa, xb);
            ev[cyc+LAT+2] = 1'b1;
            er[cyc+LAT+2] = dir ? dr : r[31:0];
            ef[cyc+LAT+2] = dir ? df : r[35:32];
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic dir_op(input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] dr, input logic [3:0] df);
        do_cycle(1'b0, 1'b1, xa, xb, 1'b1, dr, df);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin iss[k] = 1'b0; pp[k] = '0; end
        for (int k = 0; k < N + LAT + 4; k++) begin ev[k] = 1'b0; er[k] = '0; ef[k] = '0; end

        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(2);

        dir_op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);
        dir_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000);
        dir_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001);
`ifdef FP_MULT_RNE_EN
        dir_op(32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101);
`else
        dir_op(32'h7F00_0000, 32'h4000_0000, 32'h7F7F_FFFF, 4'b0101);
`endif
        dir_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000);
        dir_op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 4'b0000);
        idle(3);
        dir_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001);
        idle(LAT + 4);

        for (int i = 0; i < 300; i++)
            do_cycle(1'b0, $urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'b0, '0, '0);
        idle(LAT + 4);

        for (int i = 0; i < 20; i++) begin
            if (i == 10) do_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
            do_cycle(1'b0, 1'b1, rand_op(), rand_op(), 1'b0, '0, '0);
        end
        idle(LAT + 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
